sync_fifo_thresh: RTL and testbench

//  Single-clock FIFO for same-domain buffering: next generation of the dual-clock FIFO top.

---
 rtl/sync_fifo_thresh_if.sv | 49 ++++
 rtl/sync_fifo_thresh.sv | 133 +++++++++++++
 tb/tb_sync_fifo_thresh.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_thresh_if.sv
// Producer/consumer bundle for sync_fifo_thresh: write side, read side and status.
// The FIFO takes the slave view; whatever feeds and drains it takes the master view.
interface sync_fifo_thresh_if #(
   parameter int width   = 8,
   parameter int p_width = 4
);
   logic               flush;
   logic [width-1:0]   wr_data;
   logic               w_inc;
   logic               r_inc;
   logic [width-1:0]   rd_data;
   logic               full;
   logic               empty;
   logic               almost_full;
   logic               almost_empty;
   logic [p_width-1:0] count;
   logic               overflow;
   logic               underflow;

   modport master (
      output flush,
      output wr_data,
      output w_inc,
      output r_inc,
      input  rd_data,
      input  full,
      input  empty,
      input  almost_full,
      input  almost_empty,
      input  count,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  flush,
      input  wr_data,
      input  w_inc,
      input  r_inc,
      output rd_data,
      output full,
      output empty,
      output almost_full,
      output almost_empty,
      output count,
      output overflow,
      output underflow
   );
endinterface

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds,
// synchronous flush, overflow/underflow pulses and a registered or fall-through read port.
module sync_fifo_thresh #(
   parameter int width    = 8,
   parameter int p_width  = 4,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input logic               clk,
   input logic               rst_n,
   sync_fifo_thresh_if.slave fifo
);
   localparam int A_W   = p_width - 1;
   localparam int DEPTH = 1 << A_W;

   localparam logic [p_width-1:0] DEPTH_CNT = p_width'(DEPTH);
   localparam logic [p_width-1:0] AF_CNT    = p_width'(AF_LEVEL);
   localparam logic [p_width-1:0] AE_CNT    = p_width'(AE_LEVEL);

   generate
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
         $error("sync_fifo_thresh: AF_LEVEL must lie in 1..DEPTH");
      end
      if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
         $error("sync_fifo_thresh: AE_LEVEL must lie in 0..DEPTH-1");
      end
   endgenerate

   logic [width-1:0]   mem [DEPTH];
   logic [p_width-1:0] wptr;
   logic [p_width-1:0] rptr;
   logic [p_width-1:0] count_q;
   logic [p_width-1:0] count_next;
   logic               full_q;
   logic               empty_q;
   logic               af_q;
   logic               ae_q;
   logic               ovf_q;
   logic               udf_q;
   logic               wr_ok;
   logic               rd_ok;
   logic [A_W-1:0]     waddr;
   logic [A_W-1:0]     raddr;

   // Acceptance looks only at this cycle's flags, so a read never makes room for a
   // same-cycle write and a write never feeds a same-cycle read.
   assign wr_ok = fifo.w_inc & ~full_q  & ~fifo.flush;
   assign rd_ok = fifo.r_inc & ~empty_q & ~fifo.flush;
   assign waddr = wptr[A_W-1:0];
   assign raddr = rptr[A_W-1:0];

   always_comb begin
      count_next = count_q;
      if (fifo.flush) begin
         count_next = '0;
      end else begin
         count_next = count_q + p_width'(wr_ok) - p_width'(rd_ok);
      end
   end

   // Binary pointers carry one extra wrap bit beyond the address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (fifo.flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + p_width'(1);
         end
         if (rd_ok) begin
            rptr <= rptr + p_width'(1);
         end
      end
   end

   // Status flags are derived from the next count so they move on the same edge as count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_next;
         full_q  <= (count_next == DEPTH_CNT);
         empty_q <= (count_next == '0);
         af_q    <= (count_next >= AF_CNT);
         ae_q    <= (count_next <= AE_CNT);
         ovf_q   <= fifo.w_inc & full_q  & ~fifo.flush;
         udf_q   <= fifo.r_inc & empty_q & ~fifo.flush;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[waddr] <= fifo.wr_data;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign fifo.rd_data = mem[raddr];
      end else begin : g_reg
         logic [width-1:0] rd_data_q;

         // Holds its last value through empty and flush; only an accepted read reloads it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_q <= '0;
            end else if (rd_ok) begin
               rd_data_q <= mem[raddr];
            end
         end

         assign fifo.rd_data = rd_data_q;
      end
   endgenerate

   assign fifo.count        = count_q;
   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = af_q;
   assign fifo.almost_empty = ae_q;
   assign fifo.overflow     = ovf_q;
   assign fifo.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Drives a registered-read and a fall-through sync_fifo_thresh with identical traffic and
// scores both against a queue-based model of the FIFO.
module tb_sync_fifo_thresh;
   localparam int W     = 8;
   localparam int PW    = 4;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_thresh_if #(.width(W), .p_width(PW)) if0 ();
   sync_fifo_thresh_if #(.width(W), .p_width(PW)) if1 ();

   sync_fifo_thresh #(
      .width(W), .p_width(PW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
   ) dut0 (
      .clk(clk),
      .rst_n(rst_n),
      .fifo(if0)
   );

   sync_fifo_thresh #(
      .width(W), .p_width(PW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
   ) dut1 (
      .clk(clk),
      .rst_n(rst_n),
      .fifo(if1)
   );

   typedef struct {
      int           count;
      bit           full;
      bit           empty;
      bit           af;
      bit           ae;
      bit           ovf;
      bit           udf;
      logic [W-1:0] rd0;
      bit           chk1;
      logic [W-1:0] rd1;
   } exp_t;

   exp_t         sbq[$];
   logic [W-1:0] mq[$];
   logic [W-1:0] rd0_model;
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " count0"}, 32'(if0.count), 32'd0);
      checkOutput({tag, " empty0"}, 32'(if0.empty), 32'd1);
      checkOutput({tag, " full0"}, 32'(if0.full), 32'd0);
      checkOutput({tag, " ae0"}, 32'(if0.almost_empty), 32'd1);
      checkOutput({tag, " af0"}, 32'(if0.almost_full), 32'd0);
      checkOutput({tag, " ovf0"}, 32'(if0.overflow), 32'd0);
      checkOutput({tag, " udf0"}, 32'(if0.underflow), 32'd0);
      checkOutput({tag, " rd0"}, 32'(if0.rd_data), 32'd0);
      checkOutput({tag, " count1"}, 32'(if1.count), 32'd0);
      checkOutput({tag, " empty1"}, 32'(if1.empty), 32'd1);
      checkOutput({tag, " ae1"}, 32'(if1.almost_empty), 32'd1);
   endtask

   // One call = one clock: drive inputs, advance the model, queue what the DUTs must show after the edge.
   task automatic applyStimulus(input bit w, input bit r, input bit f, input logic [W-1:0] d);
      exp_t e;
      bit   was_full;
      bit   was_empty;
      if0.w_inc = w;  if1.w_inc = w;
      if0.r_inc = r;  if1.r_inc = r;
      if0.flush = f;  if1.flush = f;
      if0.wr_data = d; if1.wr_data = d;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      e.ovf = w && was_full && !f;
      e.udf = r && was_empty && !f;
      if (f) begin
         mq.delete();
      end else begin
         if (r && !was_empty) rd0_model = mq.pop_front();
         if (w && !was_full) mq.push_back(d);
      end
      e.count = mq.size();
      e.full  = (e.count == DEPTH);
      e.empty = (e.count == 0);
      e.af    = (e.count >= AF);
      e.ae    = (e.count <= AE);
      e.rd0   = rd0_model;
      e.chk1  = !e.empty;
      e.rd1   = e.empty ? '0 : mq[0];
      @(posedge clk);
      sbq.push_back(e);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
   endtask

   // Monitor: whatever was queued for the last edge is compared half a cycle later.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         checkOutput("count0", 32'(if0.count), 32'(mon_e.count));
         checkOutput("full0", 32'(if0.full), 32'(mon_e.full));
         checkOutput("empty0", 32'(if0.empty), 32'(mon_e.empty));
         checkOutput("af0", 32'(if0.almost_full), 32'(mon_e.af));
         checkOutput("ae0", 32'(if0.almost_empty), 32'(mon_e.ae));
         checkOutput("ovf0", 32'(if0.overflow), 32'(mon_e.ovf));
         checkOutput("udf0", 32'(if0.underflow), 32'(mon_e.udf));
         checkOutput("rd0", 32'(if0.rd_data), 32'(mon_e.rd0));
         checkOutput("count1", 32'(if1.count), 32'(mon_e.count));
         checkOutput("full1", 32'(if1.full), 32'(mon_e.full));
         checkOutput("empty1", 32'(if1.empty), 32'(mon_e.empty));
         checkOutput("af1", 32'(if1.almost_full), 32'(mon_e.af));
         checkOutput("ae1", 32'(if1.almost_empty), 32'(mon_e.ae));
         checkOutput("ovf1", 32'(if1.overflow), 32'(mon_e.ovf));
         checkOutput("udf1", 32'(if1.underflow), 32'(mon_e.udf));
         if (mon_e.chk1) begin
            checkOutput("rd1 head", 32'(if1.rd_data), 32'(mon_e.rd1));
         end
      end
   end

   initial begin
      if0.w_inc = 1'b0; if1.w_inc = 1'b0;
      if0.r_inc = 1'b0; if1.r_inc = 1'b0;
      if0.flush = 1'b0; if1.flush = 1'b0;
      if0.wr_data = '0; if1.wr_data = '0;
      rd0_model = '0;
      #12;
      checkResetState("init");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full, then one rejected write.
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, W'(i));
      applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
      idle();

      // Drain everything, then one rejected read.
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      idle();

      // Single word: fall-through head appears before any read.
      applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
      idle();
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      idle();

      // Steady state at four words with wrapping pointers, then simultaneous access at full.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, W'($urandom));
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, W'($urandom));
      while (mq.size() < DEPTH) applyStimulus(1'b1, 1'b0, 1'b0, W'($urandom));
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
      idle();
      while (mq.size() > 0) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      idle();

      // Flush outranks simultaneous read and write.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, W'(8'h50 + i));
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h99);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      idle();

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 31) == 0), W'($urandom));
      end

      // Asynchronous reset in the middle of a write burst.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, W'($urandom));
      if0.w_inc = 1'b1; if1.w_inc = 1'b1;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      mq.delete();
      rd0_model = '0;
      #1;
      checkResetState("async");
      if0.w_inc = 1'b0; if1.w_inc = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, W'(8'h10 + i));
      applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      idle();
      idle();
      @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
